// File: rtl/hwpe_ctrl_reqrsp_target.sv
// Register-file target for the reqrsp protocol.
// Requests decode a word index from the address. The index selects one of N_REGS
// byte-strobed registers, a read-only status word, or an unmapped hole. Every
// accepted request produces one response, and responses queue in a 2-entry FIFO.

// One read/write register with per-byte write enables.
module hwpe_ctrl_reqrsp_reg #(
  parameter int unsigned DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] strb_i,
  input  logic [DW-1:0]   data_i,
  output logic [DW-1:0]   q_o
);

  // Byte-granular update; clear wins over a write in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else if (clear_i) begin
      q_o <= '0;
    end else if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (strb_i[b]) q_o[b*8 +: 8] <= data_i[b*8 +: 8];
      end
    end
  end

endmodule

module hwpe_ctrl_reqrsp_target #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned N_REGS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [AW-1:0]      q_addr_i,
  input  logic               q_write_i,
  input  logic [DW/8-1:0]    q_strb_i,
  input  logic [DW-1:0]      q_data_i,
  input  logic               q_valid_i,
  output logic               q_ready_o,
  output logic [DW-1:0]      p_data_o,
  output logic               p_valid_o,
  input  logic               p_ready_i,
  output logic [N_REGS*DW-1:0] regs_o,
  input  logic [DW-1:0]      status_i
);

  // The index field is wide enough to also encode the status slot at N_REGS.
  localparam int unsigned IW = $clog2(N_REGS + 1);
  localparam int unsigned SW = DW / 8;

  typedef struct packed {
    logic          write;
    logic [IW-1:0] idx;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } req_t;

  req_t                         req;
  logic                         push, pop;
  logic [DW-1:0]                rd_data, rsp_data;
  logic [N_REGS-1:0]            reg_we;
  logic [N_REGS-1:0][DW-1:0]    regs;
  logic [1:0][DW-1:0]           fifo_mem;
  logic                         wr_ptr, rd_ptr;
  logic [1:0]                   count;
  logic                         addr_unused;

  // Byte-offset bits and the bits above the index field do not take part in decode.
  assign addr_unused = ^q_addr_i;

  // Gather the request fields into a single bundle.
  always_comb begin
    req       = '0;
    req.write = q_write_i;
    req.idx   = q_addr_i[2 +: IW];
    req.strb  = q_strb_i;
    req.data  = q_data_i;
  end

  // The handshake depends only on FIFO occupancy. Clear suppresses any push or pop.
  assign q_ready_o = (count != 2'd2);
  assign p_valid_o = (count != 2'd0);
  assign p_data_o  = fifo_mem[rd_ptr];
  assign push      = q_valid_i & q_ready_o & ~clear_i;
  assign pop       = p_valid_o & p_ready_i & ~clear_i;

  // Read mux, sampled at acceptance. The status word is read-only, and unmapped indices read as zero.
  always_comb begin
    rd_data = '0;
    if (req.idx == IW'(N_REGS)) rd_data = status_i;
    for (int k = 0; k < N_REGS; k++) begin
      if (req.idx == IW'(k)) rd_data = regs[k];
    end
  end

  // A write's response carries no data.
  assign rsp_data = req.write ? '0 : rd_data;

  // Per-register write enables. Status and unmapped indices match no register.
  always_comb begin
    reg_we = '0;
    for (int k = 0; k < N_REGS; k++) begin
      reg_we[k] = push & req.write & (req.idx == IW'(k));
    end
  end

  // Register array, one instance per index.
  for (genvar k = 0; k < N_REGS; k++) begin : g_reg
    hwpe_ctrl_reqrsp_reg #(.DW(DW)) i_reg (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .we_i    (reg_we[k]),
      .strb_i  (req.strb),
      .data_i  (req.data),
      .q_o     (regs[k])
    );
  end

  assign regs_o = regs;

  // Two-entry response ring. Push and pop together leave the count unchanged,
  // and the read pointer advancing onto the fresh entry keeps the order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_mem <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (clear_i) begin
      fifo_mem <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rsp_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/hwpe_ctrl_reqrsp_target.md
HWPE_CTRL_REQRSP_TARGET -- requirements
Module: hwpe_ctrl_reqrsp_target

Interface
Parameters:
REQ-001 SHALL have parameter AW, default 32, request address width in bits.
REQ-002 SHALL have parameter DW, default 32, data width in bits; legal values are multiples of 8 only.
REQ-003 SHALL have parameter N_REGS, default 8, number of read/write registers; legal range is 1..64.
Ports:
REQ-004 SHALL have port clk_i, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port clear_i, input, 1, synchronous soft clear.
REQ-007 SHALL have port q_addr_i, input, AW, request byte address.
REQ-008 SHALL have port q_write_i, input, 1, request is a write (1) or a read (0).
REQ-009 SHALL have port q_strb_i, input, DW/8, write byte strobes.
REQ-010 SHALL have port q_data_i, input, DW, write data.
REQ-011 SHALL have port q_valid_i, input, 1, request valid.
REQ-012 SHALL have port q_ready_o, output, 1, request ready.
REQ-013 SHALL have port p_data_o, output, DW, response data.
REQ-014 SHALL have port p_valid_o, output, 1, response valid.
REQ-015 SHALL have port p_ready_i, input, 1, response ready.
REQ-016 SHALL have port regs_o, output, N_REGS*DW, flat register contents; register k occupies bits [k*DW +: DW].
REQ-017 SHALL have port status_i, input, DW, read-only status word.

Function
REQ-018 SHALL act as the target end of the reqrsp protocol; the request handshake completes when q_valid_i & q_ready_o, and the response handshake completes when p_valid_o & p_ready_i.
REQ-019 SHALL decode index idx = q_addr_i[2 +: IW], where IW = $clog2(N_REGS+1); address bits [1:0] and bits above the idx field SHALL be ignored.
REQ-020 SHALL treat idx < N_REGS as register idx, idx == N_REGS as status_i (read-only), and any other idx as unmapped.
REQ-021 SHALL, on an accepted write to a register, update each byte b for which q_strb_i[b]=1 at the next clock edge; bytes with strobe 0 SHALL be unchanged.
REQ-022 SHALL ignore accepted writes to the status index or to unmapped indices, with no state change.
REQ-023 SHALL capture read data at the cycle of acceptance: the register value, status_i, or 0 for unmapped indices.
REQ-024 SHALL produce exactly one response per accepted request, in acceptance order; the response data of a write SHALL be 0.
REQ-025 SHALL buffer responses in a 2-entry FIFO whose head drives p_data_o and p_valid_o; p_valid_o = (count != 0).
REQ-026 SHALL drive q_ready_o = (count < 2) combinationally from the FIFO count, with no dependency on p_ready_i.
REQ-027 SHALL have a minimum latency of 1: a request accepted in cycle t SHALL have p_valid_o=1 in cycle t+1 if the FIFO was empty.
REQ-028 SHALL hold p_data_o stable while p_valid_o=1 and p_ready_i=0.
REQ-029 SHALL, on a simultaneous push and pop, keep count unchanged and preserve ordering; on a push when count==1 with a pop, the new entry SHALL become head in the next cycle.
REQ-030 SHALL make a write accepted in cycle t visible to a read accepted in cycle t+1 or later.
REQ-031 SHALL, when count==2, not accept requests regardless of q_valid_i, and SHALL take no stray action from that q_valid_i.
REQ-032 SHALL, when clear_i=1, set count to 0 and all registers to 0 at the next edge, drop any request presented in that cycle without effect, and give clear_i priority over all handshakes.
REQ-033 SHALL have a FIFO count 2 bits wide and never exceeding 2.

Reset
REQ-034 SHALL, on rst_i=1 asynchronously, set all registers to 0, FIFO count to 0, FIFO storage to 0, p_valid_o=0 and p_data_o=0, and hold q_ready_o=1.
REQ-035 SHALL, on rst_i assertion mid-transaction, discard pending responses; the first accepted request after deassertion SHALL be served normally.

Verification
REQ-036 Basic write/read: write 0xA5A5A5A5 to addr 0x08 with strb 0xF, then read 0x08 -> responses 0x0 then 0xA5A5A5A5, each 1 cycle after acceptance; regs_o[2*DW +: DW]=0xA5A5A5A5.
REQ-037 Strobes: reg1=0x11223344, write 0xFFFFFFFF with strb 0b0101 -> read returns 0x11FF33FF.
REQ-038 Backpressure: p_ready_i=0, 3 back-to-back reads -> q_ready_o drops after 2 accepts; third held; releasing p_ready_i drains in order with no loss.
REQ-039 Status/unmapped (N_REGS=8): read 0x20 with status_i=0xCAFE0001 -> 0xCAFE0001; write 0x20 -> no change; read 0x3C -> 0.
REQ-040 Clear and reset: 2 responses pending, pulse clear_i -> p_valid_o=0 and regs_o=0 next cycle; assert rst_i mid-stream -> p_valid_o=0 immediately, with no clock edge required.
